// File: rtl/spu_ex_pkg.sv
// Shared types and helpers for the SPU execute stage: opcode and element-size
// encodings, default widths, and the illegal-combination decoder.
package spu_ex_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int PC_W_DEF   = 11;
    localparam int REG_W_DEF  = 7;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_CEQ = 4'd5,
        OP_CGT = 4'd6,
        OP_SHL = 4'd7,
        OP_MPY = 4'd8,
        OP_SEL = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ESZ_BYTE = 2'd0,
        ESZ_HALF = 2'd1,
        ESZ_WORD = 2'd2,
        ESZ_ILL  = 2'd3
    } esz_e;

    // Multiply only exists for word lanes; codes 10..15 are unassigned.
    function automatic logic is_illegal(input logic [3:0] op, input logic [1:0] esz);
        return (esz == ESZ_ILL) || (op >= 4'd10) || ((op == OP_MPY) && (esz != ESZ_WORD));
    endfunction

endpackage

// File: rtl/spu_simd_alu.sv
// Combinational SIMD lane ALU: every op except MPY, evaluated for byte, half
// and word lanes in parallel and selected by element size.
module spu_simd_alu
    import spu_ex_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_e               op,
    input  esz_e              esz,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] result
);

    logic [2:0][DATA_W-1:0] lane_res;

    for (genvar gs = 0; gs < 3; gs++) begin : g_size
        localparam int EW   = 8 << gs;
        localparam int SH_W = $clog2(EW);
        for (genvar gi = 0; gi < DATA_W / EW; gi++) begin : g_lane
            logic [EW-1:0] ea;
            logic [EW-1:0] eb;
            logic [EW-1:0] er;

            assign ea = a[gi*EW +: EW];
            assign eb = b[gi*EW +: EW];

            always_comb begin
                er = '0;
                case (op)
                    OP_ADD:  er = ea + eb;
                    OP_SUB:  er = ea - eb;
                    OP_AND:  er = ea & eb;
                    OP_OR:   er = ea | eb;
                    OP_XOR:  er = ea ^ eb;
                    OP_CEQ:  er = {EW{ea == eb}};
                    OP_CGT:  er = {EW{$signed(ea) > $signed(eb)}};
                    // Shift amount is the B element modulo the element width.
                    OP_SHL:  er = ea << eb[SH_W-1:0];
                    default: er = '0;
                endcase
            end

            assign lane_res[gs][gi*EW +: EW] = er;
        end
    end

    always_comb begin
        result = '0;
        if (esz != ESZ_ILL) begin
            if (op == OP_SEL) begin
                result = (c & b) | (~c & a);
            end else begin
                case (esz)
                    ESZ_BYTE: result = lane_res[0];
                    ESZ_HALF: result = lane_res[1];
                    ESZ_WORD: result = lane_res[2];
                    default:  result = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/spu_execute_pipe.sv
// SPU execute stage: single-entry registered output with valid/ready on both
// sides, lane ALU, multi-cycle word multiply and flush.
module spu_execute_pipe
    import spu_ex_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int REG_W      = REG_W_DEF,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc_plus8,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_ra,
    input  logic [DATA_W-1:0] in_rb,
    input  logic [DATA_W-1:0] in_rc,
    input  logic              in_use_imm,
    input  logic [3:0]        in_op,
    input  logic [1:0]        in_esz,
    input  logic [REG_W-1:0]  in_rt_a,
    input  logic [REG_W-1:0]  in_rt_b,
    input  logic              in_dst_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rt,
    output logic              out_zero,
    output logic [PC_W-1:0]   out_jump_pc,
    output logic              out_illegal
);

    localparam int LANES32 = DATA_W / 32;
    localparam int CNT_W   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic {ST_IDLE, ST_MUL_BUSY} state_e;

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [DATA_W-1:0]  opnd_b;
    logic [DATA_W-1:0]  alu_result;
    logic [PC_W-1:0]    imm_sh;
    logic [PC_W-1:0]    jump_in;
    logic [REG_W-1:0]   rt_in;
    logic               in_illegal;
    logic               in_is_mpy;
    logic               in_fire;
    logic               slot_free;
    logic               load;

    logic [16*LANES32-1:0] in_mul_a, in_mul_b;
    logic [16*LANES32-1:0] mul_a_src, mul_b_src;
    logic [16*LANES32-1:0] mul_a_reg, mul_b_reg;
    logic [DATA_W-1:0]     mul_result;
    logic [DATA_W-1:0]     pend_store_reg;
    logic [REG_W-1:0]      pend_rt_reg;
    logic [PC_W-1:0]       pend_jump_reg;

    logic                  out_valid_reg, out_valid_next;
    logic [DATA_W-1:0]     out_result_reg, res_next;
    logic [DATA_W-1:0]     out_store_reg, store_next;
    logic [REG_W-1:0]      out_rt_reg, rt_next;
    logic [PC_W-1:0]       out_jump_reg, jump_next;
    logic                  out_zero_reg;
    logic                  out_illegal_reg, illegal_next;

    assign opnd_b     = in_use_imm ? in_imm : in_rb;
    assign imm_sh     = {in_imm[PC_W-3:0], 2'b00};
    assign jump_in    = in_pc_plus8 + imm_sh;
    assign rt_in      = in_dst_sel ? in_rt_b : in_rt_a;
    assign in_illegal = is_illegal(in_op, in_esz);
    assign in_is_mpy  = (in_op == OP_MPY) && !in_illegal;
    assign slot_free  = !out_valid_reg || out_ready;
    assign in_ready   = rst_n && (state_reg == ST_IDLE) && slot_free && !flush;
    assign in_fire    = in_valid && in_ready;

    spu_simd_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_e'(in_op)),
        .esz    (esz_e'(in_esz)),
        .a      (in_ra),
        .b      (opnd_b),
        .c      (in_rc),
        .result (alu_result)
    );

    // While busy the product comes from the latched operands, otherwise
    // straight from the inputs (the single-cycle multiply case).
    assign mul_a_src = (state_reg == ST_MUL_BUSY) ? mul_a_reg : in_mul_a;
    assign mul_b_src = (state_reg == ST_MUL_BUSY) ? mul_b_reg : in_mul_b;

    for (genvar gi = 0; gi < LANES32; gi++) begin : g_mul
        logic signed [15:0] pa;
        logic signed [15:0] pb;
        logic signed [31:0] prod;

        assign in_mul_a[gi*16 +: 16]   = in_ra[gi*32 +: 16];
        assign in_mul_b[gi*16 +: 16]   = opnd_b[gi*32 +: 16];
        assign pa                      = mul_a_src[gi*16 +: 16];
        assign pb                      = mul_b_src[gi*16 +: 16];
        assign prod                    = pa * pb;
        assign mul_result[gi*32 +: 32] = prod;
    end

    // The multiply result lands on the edge where the countdown reaches zero,
    // so the accept-to-valid latency equals MUL_CYCLES.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_fire) begin
                    if (in_is_mpy && (MUL_CYCLES > 1)) begin
                        state_next = ST_MUL_BUSY;
                        cnt_next   = CNT_W'(MUL_CYCLES - 1);
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if ((cnt_reg <= CNT_W'(1)) && slot_free) begin
                    load       = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            load       = 1'b0;
        end
    end

    always_comb begin
        if (state_reg == ST_MUL_BUSY) begin
            res_next     = mul_result;
            store_next   = pend_store_reg;
            rt_next      = pend_rt_reg;
            jump_next    = pend_jump_reg;
            illegal_next = 1'b0;
        end else begin
            res_next     = in_illegal ? '0 : (in_is_mpy ? mul_result : alu_result);
            store_next   = in_rb;
            rt_next      = rt_in;
            jump_next    = jump_in;
            illegal_next = in_illegal;
        end
        out_valid_next = out_valid_reg && !out_ready;
        if (load) begin
            out_valid_next = 1'b1;
        end
        if (flush) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            out_valid_reg   <= 1'b0;
            out_result_reg  <= '0;
            out_store_reg   <= '0;
            out_rt_reg      <= '0;
            out_jump_reg    <= '0;
            out_zero_reg    <= 1'b0;
            out_illegal_reg <= 1'b0;
            mul_a_reg       <= '0;
            mul_b_reg       <= '0;
            pend_store_reg  <= '0;
            pend_rt_reg     <= '0;
            pend_jump_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            if (load) begin
                out_result_reg  <= res_next;
                out_store_reg   <= store_next;
                out_rt_reg      <= rt_next;
                out_jump_reg    <= jump_next;
                out_zero_reg    <= (res_next == '0);
                out_illegal_reg <= illegal_next;
            end
            if (in_fire) begin
                mul_a_reg      <= in_mul_a;
                mul_b_reg      <= in_mul_b;
                pend_store_reg <= in_rb;
                pend_rt_reg    <= rt_in;
                pend_jump_reg  <= jump_in;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_result     = out_result_reg;
    assign out_store_data = out_store_reg;
    assign out_rt         = out_rt_reg;
    assign out_zero       = out_zero_reg;
    assign out_jump_pc    = out_jump_reg;
    assign out_illegal    = out_illegal_reg;

endmodule

// File: tb/tb_spu_execute_pipe.sv
// Bench for spu_execute_pipe: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model of the stage.
module tb_spu_execute_pipe;

    localparam int DW = 128;
    localparam int PW = 11;
    localparam int RW = 7;
    localparam int MC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pc_plus8;
    logic [DW-1:0] in_imm, in_ra, in_rb, in_rc;
    logic          in_use_imm;
    logic [3:0]    in_op;
    logic [1:0]    in_esz;
    logic [RW-1:0] in_rt_a, in_rt_b;
    logic          in_dst_sel;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result, out_store_data;
    logic [RW-1:0] out_rt;
    logic          out_zero;
    logic [PW-1:0] out_jump_pc;
    logic          out_illegal;

    spu_execute_pipe #(
        .DATA_W(DW), .PC_W(PW), .REG_W(RW), .MUL_CYCLES(MC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_plus8(in_pc_plus8), .in_imm(in_imm),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_use_imm(in_use_imm), .in_op(in_op), .in_esz(in_esz),
        .in_rt_a(in_rt_a), .in_rt_b(in_rt_b), .in_dst_sel(in_dst_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_rt(out_rt), .out_zero(out_zero),
        .out_jump_pc(out_jump_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] result;
        logic [DW-1:0] store;
        logic [RW-1:0] rt;
        logic          zero;
        logic [PW-1:0] jump;
        logic          illegal;
    } ent_t;

    // Model state: the held output entry and an optional multiply in flight
    // that becomes writable at a given edge number.
    ent_t m_out, m_pend;
    bit   m_valid, m_busy, m_rstd;
    int   m_due;
    int   edge_n = 0;
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic bit m_illegal(input logic [3:0] op, input logic [1:0] esz);
        return (esz == 2'd3) || (op >= 4'd10) || (op == 4'd8 && esz != 2'd2);
    endfunction

    function automatic longint sx(input longint unsigned v, input int w);
        longint unsigned half = 64'd1 << (w - 1);
        return (v >= half) ? longint'(v) - longint'(half) - longint'(half) : longint'(v);
    endfunction

    function automatic logic [DW-1:0] m_alu(input logic [3:0] op, input logic [1:0] esz,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        logic [DW-1:0] res, ta, tb;
        longint unsigned ea, eb, r, mask;
        int w;
        if (m_illegal(op, esz)) return '0;
        if (op == 4'd9) return (c & b) | (~c & a);
        w    = 8 << esz;
        mask = (64'd1 << w) - 64'd1;
        res  = '0;
        for (int i = 0; i < DW / w; i++) begin
            ta = a >> (i * w);
            tb = b >> (i * w);
            ea = ta[63:0] & mask;
            eb = tb[63:0] & mask;
            case (op)
                4'd0: r = ea + eb;
                4'd1: r = ea - eb;
                4'd2: r = ea & eb;
                4'd3: r = ea | eb;
                4'd4: r = ea ^ eb;
                4'd5: r = (ea == eb) ? mask : 64'd0;
                4'd6: r = (sx(ea, w) > sx(eb, w)) ? mask : 64'd0;
                4'd7: r = ea << (eb % 64'(w));
                4'd8: r = longint'(sx(ea & 64'hFFFF, 16) * sx(eb & 64'hFFFF, 16));
                default: r = 64'd0;
            endcase
            r   = r & mask;
            res = res | ({64'd0, r} << (i * w));
        end
        return res;
    endfunction

    function automatic ent_t make_entry();
        ent_t e;
        logic [DW-1:0] b = in_use_imm ? in_imm : in_rb;
        logic [PW-1:0] imm_lo = in_imm[PW-1:0];
        e.result  = m_alu(in_op, in_esz, in_ra, b, in_rc);
        e.store   = in_rb;
        e.rt      = in_dst_sel ? in_rt_b : in_rt_a;
        e.zero    = (e.result == '0);
        e.jump    = PW'((int'(in_pc_plus8) + int'(imm_lo) * 4) % (1 << PW));
        e.illegal = m_illegal(in_op, in_esz);
        return e;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, want %h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_update(input bit acc_ok);
        ent_t e;
        bit   sf;
        edge_n++;
        if (!rst_n) begin
            m_valid = 0;
            m_busy  = 0;
            m_rstd  = 1;
            m_out   = '{default: '0};
            return;
        end
        m_rstd = 0;
        if (flush) begin
            m_valid = 0;
            m_busy  = 0;
            return;
        end
        sf = !m_valid || out_ready;
        if (m_valid && out_ready) m_valid = 0;
        if (m_busy) begin
            if (edge_n >= m_due && sf) begin
                m_out   = m_pend;
                m_valid = 1;
                m_busy  = 0;
            end
        end else if (in_valid && acc_ok) begin
            e = make_entry();
            if (in_op == 4'd8 && in_esz == 2'd2) begin
                m_pend = e;
                m_due  = edge_n + MC - 1;
                if (m_due <= edge_n) begin
                    m_out   = e;
                    m_valid = 1;
                end else begin
                    m_busy = 1;
                end
            end else begin
                m_out   = e;
                m_valid = 1;
            end
        end
    endtask

    // One cycle: compare DUT against the model, then advance both.
    task automatic step();
        bit exp_ready;
        #1;
        exp_ready = rst_n && !m_busy && (!m_valid || out_ready) && !flush;
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, m_valid);
        if (m_valid || m_rstd) begin
            chk("out_result", out_result, m_out.result);
            chk("out_store_data", out_store_data, m_out.store);
            chk("out_rt", out_rt, m_out.rt);
            chk("out_zero", out_zero, m_out.zero);
            chk("out_jump_pc", out_jump_pc, m_out.jump);
            chk("out_illegal", out_illegal, m_out.illegal);
        end
        n_vec++;
        @(posedge clk);
        model_update(exp_ready);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] esz,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = v; in_op = op; in_esz = esz; in_ra = a; in_rb = b;
        in_rc = '0; in_imm = '0; in_use_imm = 0; in_pc_plus8 = '0;
        in_rt_a = 7'd5; in_rt_b = 7'd9; in_dst_sel = 0;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [DW-1:0] v;
        int r;
        rst_n = 0; flush = 0; out_ready = 1;
        drive(0, 4'd0, 2'd0, '0, '0);
        m_valid = 0; m_busy = 0; m_rstd = 1; m_out = '{default: '0}; m_pend = '{default: '0}; m_due = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        step();
        rst_n = 1;
        #1 chk("ready_after_release", in_ready, 1);

        // ADD word with per-word overflow
        drive(1, 4'd0, 2'd2, {4{32'h7FFFFFFF}}, {4{32'd1}});
        in_dst_sel = 1;
        step();
        chk("add_result", out_result, {4{32'h80000000}});
        chk("add_valid", out_valid, 1);
        chk("add_zero", out_zero, 0);
        chk("add_illegal", out_illegal, 0);
        chk("add_rt", out_rt, 7'd9);
        chk("add_store", out_store_data, {4{32'd1}});

        // CEQ byte then SUB with equal operands, back to back
        drive(1, 4'd5, 2'd0, '0, '0);
        step();
        chk("ceq_result", out_result, {DW{1'b1}});
        chk("ceq_zero", out_zero, 0);
        v = rnd128();
        drive(1, 4'd1, 2'd2, v, v);
        #1 chk("b2b_in_ready", in_ready, 1);
        step();
        chk("sub_result", out_result, 0);
        chk("sub_zero", out_zero, 1);

        // Jump target wraps
        drive(1, 4'd2, 2'd2, rnd128(), rnd128());
        in_pc_plus8 = 11'h7F8; in_imm = 128'd3;
        step();
        chk("jump_wrap", out_jump_pc, 11'h004);

        // Illegal opcode and MPY with byte elements
        drive(1, 4'd12, 2'd2, rnd128(), rnd128());
        step();
        chk("op12_result", out_result, 0);
        chk("op12_illegal", out_illegal, 1);
        drive(1, 4'd8, 2'd0, rnd128(), rnd128());
        step();
        chk("mpy_b_result", out_result, 0);
        chk("mpy_b_illegal", out_illegal, 1);

        // Word multiply latency, with a competing op held off while busy
        drive(1, 4'd8, 2'd2, {4{32'h0000FFFF}}, {4{32'd3}});
        step();
        drive(1, 4'd0, 2'd2, rnd128(), rnd128());
        for (int k = 1; k < MC; k++) begin
            chk($sformatf("mpy_wait%0d_valid", k), out_valid, 0);
            chk($sformatf("mpy_wait%0d_ready", k), in_ready, 0);
            step();
        end
        chk("mpy_valid", out_valid, 1);
        chk("mpy_result", out_result, {4{32'hFFFFFFFD}});
        step();

        // Backpressure holds the result for five cycles
        drive(1, 4'd4, 2'd2, {4{32'hF0F0F0F0}}, {4{32'hFF00FF00}});
        step();
        in_valid = 0; out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_result", k), out_result, {4{32'h0FF00FF0}});
            chk($sformatf("hold%0d_valid", k), out_valid, 1);
            step();
        end
        out_ready = 1;
        step();

        // Flush in the second busy cycle kills the multiply
        drive(1, 4'd8, 2'd2, rnd128(), rnd128());
        step();
        in_valid = 0;
        step();
        flush = 1;
        step();
        flush = 0;
        chk("flush_valid", out_valid, 0);
        #1 chk("flush_idle_ready", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("flush_late%0d", k), out_valid, 0);
            step();
        end

        // Reset in the middle of a multiply
        drive(1, 4'd8, 2'd2, rnd128(), rnd128());
        step();
        in_valid = 0; rst_n = 0;
        step();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_result", out_result, 0);
        chk("mrst_jump", out_jump_pc, 0);
        chk("mrst_ready", in_ready, 0);
        step();
        rst_n = 1;
        #1 chk("mrst_release_ready", in_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            flush      = ($urandom_range(0, 29) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            r          = $urandom_range(0, 19);
            in_op      = (r < 16) ? 4'(r) : 4'd8;
            in_esz     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (in_op == 4'd8 && $urandom_range(0, 3) != 0) in_esz = 2'd2;
            in_ra      = rnd128();
            in_rb      = ($urandom_range(0, 1) == 0) ? (in_ra ^ (rnd128() & rnd128() & rnd128())) : rnd128();
            in_rc      = rnd128();
            in_imm     = rnd128();
            in_use_imm = ($urandom_range(0, 3) == 0);
            in_pc_plus8 = PW'($urandom());
            in_rt_a    = RW'($urandom());
            in_rt_b    = RW'($urandom());
            in_dst_sel = 1'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/spu_execute_pipe.md
Name: spu_execute_pipe

Overview:
Registered, parametrised SPU execute stage. Computes the branch target and a SIMD ALU result over DATA_W-bit register operands with selectable element size. Adds a multi-cycle multiply path, valid/ready handshakes on both sides, and pipeline flush. Sits between register-fetch/decode and memory/writeback.

Parameters:
DATA_W, 128, operand/result width; must be a multiple of 32
PC_W, 11, program counter width
REG_W, 7, register-file address width
MUL_CYCLES, 4, multiply latency in cycles; minimum 1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  kills the in-flight op and the held output
in_valid  in  1  input op valid
in_ready  out  1  stage can accept an op
in_pc_plus8  in  PC_W  PC+8 of the op
in_imm  in  DATA_W  sign-extended immediate
in_ra  in  DATA_W  operand A
in_rb  in  DATA_W  operand B
in_rc  in  DATA_W  operand C (select mask)
in_use_imm  in  1  1: B operand = in_imm
in_op  in  4  opcode (see package)
in_esz  in  2  element size: 00 byte, 01 half, 10 word, 11 illegal
in_rt_a  in  REG_W  destination candidate (RT field)
in_rt_b  in  REG_W  destination candidate (RRR field)
in_dst_sel  in  1  0: in_rt_a, 1: in_rt_b
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  DATA_W  ALU result
out_store_data  out  DATA_W  registered in_rb (not the imm-muxed operand)
out_rt  out  REG_W  selected destination
out_zero  out  1  out_result equals 0
out_jump_pc  out  PC_W  branch target
out_illegal  out  1  illegal op/esz combination

Behaviour:
- Reset: clk and rst_n as named; rst_n is synchronous and active-low. While rst_n=0, all outputs are 0, in_ready=0, and the FSM is IDLE. in_ready=1 from the first cycle after release.
- Handshake: a transfer occurs when valid&&ready. out_* stays stable while out_valid&&!out_ready. The stage holds a single output entry.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Jump target: out_jump_pc = in_pc_plus8 + (in_imm[PC_W-1:0] << 2), truncated mod 2^PC_W. It is registered together with the result.
- Opcodes are 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 CEQ, 6 CGT, 7 SHL, 8 MPY, 9 SEL. Codes 10-15 are illegal.
- Per-element arithmetic:
  - Element-wise ops wrap.
  - CEQ and CGT (signed) return all-ones or all-zeros per element.
  - SHL is a logical left shift by B element mod element width.
  - SEL = (C & B) | (~C & A) bitwise; it ignores esz but still requires esz != 11.
- MPY is defined for word elements only: signed A[15:0] × B[15:0], giving a 32-bit product per word.
- Illegal cases (esz=11, opcode ≥10, or MPY with esz≠10): out_result=0, out_illegal=1, latency 1, no trap.
- FSM states are IDLE and MUL_BUSY.
  - IDLE: an accepted non-MPY op loads the output register next edge. Latency is 1 and the stage can accept back-to-back every cycle.
  - IDLE: an accepted MPY latches its operands, loads cnt=MUL_CYCLES-1, and moves to MUL_BUSY. If MUL_CYCLES=1, it behaves like a non-MPY op.
  - MUL_BUSY: cnt decrements to 0 and then saturates. At cnt=0 the result is written and the FSM returns to IDLE, but only if !out_valid || out_ready. Otherwise it waits at 0.
- Flush (highest priority after reset):
  - The next edge clears out_valid, returns the FSM to IDLE, and discards the multiply.
  - An input presented during a flush cycle is not accepted.
  - Output data registers may keep stale values; only out_valid matters.
- Simultaneous output drain and new accept in one cycle: the new result replaces the old one with no bubble.
- out_zero is computed over the full DATA_W result.

Decomposition:
- Package spu_ex_pkg holds:
  - op_e enum (4-bit)
  - esz_e enum (2-bit)
  - localparams DATA_W_DEF=128, PC_W_DEF=11, REG_W_DEF=7
  - function is_illegal(op, esz)
- Sub-module spu_simd_alu: purely combinational lane ALU for every op except MPY, parametrised by DATA_W.
- The multiply datapath and FSM stay in the top module.

Test Plan:
- ADD word, A=32'h7FFFFFFF per word, B=1, in_use_imm=0 → one cycle later out_result=4×32'h80000000, out_zero=0, out_illegal=0.
- CEQ byte, A=B=0, then SUB with A=B → results all-ones / all-zeros; out_zero=1 only on the second; back-to-back accepts, in_ready stays 1.
- MPY word, A lanes=16'hFFFF (−1), B=3, MUL_CYCLES=4 → out_valid exactly 4 cycles after accept, each word = 32'hFFFFFFFD; in_ready=0 for those cycles.
- Jump: in_pc_plus8=11'h7F8, in_imm=3 → out_jump_pc=11'h004 (wrap).
- Backpressure and flush:
  - out_ready=0 holds the result stable for 5 cycles.
  - Asserting flush mid-MPY (cycle 2) gives out_valid=0 next cycle, FSM IDLE, and no late result.
- Illegal cases: op=12 or MPY with esz=00 → out_result=0, out_illegal=1, latency 1. Reset low mid-MPY → all outputs 0, in_ready=0 until rst_n rises.
